// File: rtl/muxn_scan_if.sv
// ----------------------------------------------------------------------------
// muxn_scan_if
//   Bundles the data, control and result signals of muxn_scan.
//
//   Parameters
//     N        number of input channels (>= 1)
//     W        bits per channel (>= 1)
//     DWELL_W  width of the dwell field
//
//   Signals
//     en      cycle enable (all state frozen when low)
//     mode    0 = manual select, 1 = round-robin scan
//     sel_in  requested channel in manual mode (clamped to N-1)
//     dwell   scan mode: each channel is held for dwell+1 enabled cycles
//     d       channel k is d[k*W +: W], channel 0 in the LSB slice
//     y       registered selected data
//     ch      channel index that produced the current y
//     valid   y was updated on the last edge
//     wrap    one-cycle pulse when the scan pointer goes from N-1 to 0
//
//   Modports: master drives the inputs and observes the results;
//   slave is the multiplexer side.
// ----------------------------------------------------------------------------
interface muxn_scan_if #(
    parameter int N       = 8,
    parameter int W       = 1,
    parameter int DWELL_W = 4
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel_in;
    logic [DWELL_W-1:0] dwell;
    logic [N*W-1:0]     d;
    logic [W-1:0]       y;
    logic [SEL_W-1:0]   ch;
    logic               valid;
    logic               wrap;

    modport master (
        output en, mode, sel_in, dwell, d,
        input  y, ch, valid, wrap
    );

    modport slave (
        input  en, mode, sel_in, dwell, d,
        output y, ch, valid, wrap
    );
endinterface

// File: rtl/muxn_scan.sv
// ----------------------------------------------------------------------------
// muxn_scan
//   N-channel, W-bit multiplexer with a registered output. The channel comes
//   either from sel_in (manual mode, clamped to N-1) or from an internal
//   round-robin pointer that dwells dwell+1 enabled cycles on each channel
//   (scan mode).
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset; wins over en and mode
//     bus    muxn_scan_if.slave: en, mode, sel_in, dwell, d in;
//            y, ch, valid, wrap out (all outputs are flops)
// ----------------------------------------------------------------------------
module muxn_scan #(
    parameter int N       = 8,
    parameter int W       = 1,
    parameter int DWELL_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    muxn_scan_if.slave   bus
);
    localparam int               SEL_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);
    localparam logic [SEL_W:0]   N_EXT = (SEL_W + 1)'(N);

    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]       y_q, y_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;

    logic [SEL_W-1:0]   man_sel;
    logic [SEL_W-1:0]   pick;
    logic [W-1:0]       pick_data;
    logic               terminal;

    // Out-of-range requests (only possible when N is not a power of two)
    // fall back to the highest channel. The extra bit keeps the compare exact.
    assign man_sel  = ({1'b0, bus.sel_in} >= N_EXT) ? LAST : bus.sel_in;
    assign pick     = bus.mode ? ptr_q : man_sel;
    // Compare with >= so that shrinking dwell below the running count ends
    // the slot on the next enabled cycle instead of waiting for a wrap.
    assign terminal = (cnt_q >= bus.dwell);

    // Explicit decode keeps every slice in range even for odd N.
    always_comb begin
        pick_data = '0;
        for (int k = 0; k < N; k++) begin
            if (pick == SEL_W'(k)) begin
                pick_data = bus.d[k*W +: W];
            end
        end
    end

    // NOTE: every signal gets a default before any branch, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;

        if (bus.en) begin
            y_d     = pick_data;
            ch_d    = pick;
            valid_d = 1'b1;
            if (!bus.mode) begin
                // Manual: the pointer follows the request so a later switch
                // to scan resumes from the last manual channel.
                ptr_d = man_sel;
                cnt_d = '0;
            end else if (terminal) begin
                cnt_d  = '0;
                ptr_d  = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
                wrap_d = (ptr_q == LAST);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops
    // update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.y     = y_q;
    assign bus.ch    = ch_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule
